// File: rtl/mod_codec_cfg_seq.sv
// Codec boot sequencer: walks an 11-entry register table through an I2C write master.
// Define CFG_SEQ_RETRY_EN to re-attempt a failed write up to RETRY_MAX extra times.

module mod_codec_cfg_seq #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         SETTLE_CYCLES  = 1000,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         RETRY_MAX      = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_err_idx,
    output logic       o_i2c_start,
    output logic [6:0] o_i2c_addr,
    output logic [6:0] o_i2c_reg,
    output logic [8:0] o_i2c_data,
    output logic       o_i2c_read,
    input  logic       i_i2c_done,
    input  logic       i_i2c_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_DONE,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] wdata;
    } cfg_entry_t;

    function automatic cfg_entry_t cfg_rom(input logic [3:0] i);
        case (i)
            4'd0:    cfg_rom = '{7'h0F, 9'h000};
            4'd1:    cfg_rom = '{7'h00, 9'h017};
            4'd2:    cfg_rom = '{7'h01, 9'h017};
            4'd3:    cfg_rom = '{7'h02, 9'h079};
            4'd4:    cfg_rom = '{7'h03, 9'h079};
            4'd5:    cfg_rom = '{7'h04, 9'h012};
            4'd6:    cfg_rom = '{7'h05, 9'h000};
            4'd7:    cfg_rom = '{7'h06, 9'h000};
            4'd8:    cfg_rom = '{7'h07, 9'h042};
            4'd9:    cfg_rom = '{7'h08, 9'h000};
            4'd10:   cfg_rom = '{7'h09, 9'h001};
            default: cfg_rom = '{7'h00, 9'h000};
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [3:0]       idx, idx_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [STL_W-1:0] stl_cnt;
    logic             xfer_fail;
    cfg_entry_t       entry;

`ifdef CFG_SEQ_RETRY_EN
    localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RTY_W-1:0] retry, retry_nxt;
    // redo marks a SETTLE that precedes a re-attempt of the same entry
    logic             redo, redo_nxt;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        xfer_fail = 1'b0;
`ifdef CFG_SEQ_RETRY_EN
        retry_nxt = retry;
        redo_nxt  = redo;
`endif
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (i_start) begin
                    state_nxt = ST_ISSUE;
                    idx_nxt   = '0;
`ifdef CFG_SEQ_RETRY_EN
                    retry_nxt = '0;
                    redo_nxt  = 1'b0;
`endif
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // a done arriving on the last timeout cycle still counts
                if (i_i2c_done && !i_i2c_err)
                    state_nxt = ST_SETTLE;
                else if (i_i2c_done || tmo_cnt == TMO_LAST)
                    xfer_fail = 1'b1;
            end
            ST_SETTLE: begin
                if (stl_cnt == STL_LAST) begin
`ifdef CFG_SEQ_RETRY_EN
                    if (redo) begin
                        state_nxt = ST_ISSUE;
                        redo_nxt  = 1'b0;
                    end else
`endif
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        idx_nxt   = idx + 4'd1;
`ifdef CFG_SEQ_RETRY_EN
                        retry_nxt = '0;
`endif
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (xfer_fail) begin
`ifdef CFG_SEQ_RETRY_EN
            if (int'(retry) < RETRY_MAX) begin
                retry_nxt = retry + RTY_W'(1);
                redo_nxt  = 1'b1;
                state_nxt = ST_SETTLE;
            end else begin
                state_nxt = ST_FAIL;
            end
`else
            state_nxt = ST_FAIL;
`endif
        end
    end

    assign entry = cfg_rom(idx_nxt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            tmo_cnt    <= '0;
            stl_cnt    <= '0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_idx  <= '0;
            o_i2c_reg  <= '0;
            o_i2c_data <= '0;
`ifdef CFG_SEQ_RETRY_EN
            retry      <= '0;
            redo       <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            o_done <= (state_nxt == ST_DONE);
            o_err  <= (state_nxt == ST_FAIL);
`ifdef CFG_SEQ_RETRY_EN
            retry  <= retry_nxt;
            redo   <= redo_nxt;
`endif
            if (state_nxt == ST_ISSUE) begin
                o_i2c_reg  <= entry.reg_addr;
                o_i2c_data <= entry.wdata;
            end
            if (state == ST_WAIT && state_nxt == ST_FAIL)
                o_err_idx <= idx;
            // zero during ISSUE so the count equals cycles since the request
            if (state_nxt == ST_ISSUE)
                tmo_cnt <= '0;
            else if (state == ST_ISSUE || state == ST_WAIT)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state != ST_SETTLE)
                stl_cnt <= '0;
            else
                stl_cnt <= stl_cnt + STL_W'(1);
        end
    end

    assign o_busy      = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_SETTLE);
    assign o_i2c_start = (state == ST_ISSUE);
    assign o_i2c_addr  = DEV_ADDR;
    assign o_i2c_read  = 1'b0;

endmodule
